// File: rtl/matmul_mac_sched.sv
// rtl/matmul_mac_sched.sv - round-robin 2x2 matrix-multiply scheduler sharing one MAC
// A granted job takes 8 MAC steps plus one publish cycle; the next job can start one cycle later.
module matmul_mac_sched #(
   parameter int DW = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [1:0]      req_i,
   input  logic [8*DW-1:0] ops0_i,
   input  logic [8*DW-1:0] ops1_i,
   output logic [1:0]      gnt_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            done_id_o,
   output logic [2*DW:0]   c11_o,
   output logic [2*DW:0]   c12_o,
   output logic [2*DW:0]   c21_o,
   output logic [2*DW:0]   c22_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [2:0]      cnt_q;
   logic            last_q;
   logic            job_id_q;
   logic [1:0]      gnt_q;
   logic            busy_q;
   logic            done_q;
   logic            done_id_q;
   logic [DW-1:0]   ops_q [8];
   logic [2*DW:0]   sum_q [4];
   logic [2*DW:0]   c_q   [4];

   logic            sel_id_d;
   logic [2:0]      a_idx_d;
   logic [2:0]      b_idx_d;
   logic [2*DW-1:0] prod_d;

   // Step k: A row = k[2], A col = B row = k[0], B col = k[1].
   always_comb begin
      sel_id_d = (req_i == 2'b11) ? ~last_q : req_i[1];
      a_idx_d  = {1'b0, cnt_q[2], cnt_q[0]};
      b_idx_d  = {1'b1, cnt_q[0], cnt_q[1]};
      prod_d   = {{DW{1'b0}}, ops_q[a_idx_d]} * {{DW{1'b0}}, ops_q[b_idx_d]};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= 3'd0;
         last_q    <= 1'b1;
         job_id_q  <= 1'b0;
         gnt_q     <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         for (int i = 0; i < 8; i++) ops_q[i] <= '0;
         for (int i = 0; i < 4; i++) begin
            sum_q[i] <= '0;
            c_q[i]   <= '0;
         end
      end else begin
         gnt_q  <= 2'b00;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               busy_q <= 1'b0;
               if (|req_i) begin
                  for (int i = 0; i < 8; i++)
                     ops_q[i] <= sel_id_d ? ops1_i[i*DW +: DW] : ops0_i[i*DW +: DW];
                  for (int i = 0; i < 4; i++) sum_q[i] <= '0;
                  gnt_q    <= sel_id_d ? 2'b10 : 2'b01;
                  job_id_q <= sel_id_d;
                  busy_q   <= 1'b1;
                  cnt_q    <= 3'd0;
                  state_q  <= S_MAC;
               end
            end
            S_MAC: begin
               sum_q[cnt_q[2:1]] <= sum_q[cnt_q[2:1]] + {1'b0, prod_d};
               cnt_q             <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_q <= S_DONE;
            end
            S_DONE: begin
               for (int i = 0; i < 4; i++) c_q[i] <= sum_q[i];
               done_q    <= 1'b1;
               done_id_q <= job_id_q;
               last_q    <= job_id_q;
               state_q   <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt_o     = gnt_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign done_id_o = done_id_q;
   assign c11_o     = c_q[0];
   assign c12_o     = c_q[1];
   assign c21_o     = c_q[2];
   assign c22_o     = c_q[3];

endmodule

// File: tb/tb_matmul_mac_sched.sv
// tb/tb_matmul_mac_sched.sv - directed bench with a job-timeline model of matmul_mac_sched
module tb_matmul_mac_sched;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [1:0]   req = 2'b00;
   logic [127:0] ops0 = '0;
   logic [127:0] ops1 = '0;
   logic [1:0]   gnt;
   logic         busy, done, done_id;
   logic [32:0]  c11, c12, c21, c22;

   int n_chk = 0;
   int n_fail = 0;
   logic auto_drop = 1'b1;

   matmul_mac_sched #(.DW(16)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .ops0_i(ops0), .ops1_i(ops1),
      .gnt_o(gnt), .busy_o(busy), .done_o(done), .done_id_o(done_id),
      .c11_o(c11), .c12_o(c12), .c21_o(c21), .c22_o(c22)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] pk(input logic [15:0] a11, a12, a21, a22, b11, b12, b21, b22);
      return {b22, b21, b12, b11, a22, a21, a12, a11};
   endfunction

   // Element (r,c) of the 2x2 product C = A*B, computed in 33 bits.
   function automatic logic [32:0] cres(input logic [127:0] o, input int r, input int c);
      logic [32:0] acc;
      acc = '0;
      for (int k = 0; k < 2; k++)
         acc += 33'(o[16*(2*r+k) +: 16]) * 33'(o[16*(4+2*k+c) +: 16]);
      return acc;
   endfunction

   function automatic logic pick(input logic [1:0] r, input logic last);
      return (r == 2'b11) ? ~last : r[1];
   endfunction

   // Model: a job occupies the MAC for ages 0..9 after its acceptance edge.
   int          m_age;
   logic        m_id, m_last;
   logic [32:0] p_c [4];
   logic [1:0]  e_gnt;
   logic        e_busy, e_done, e_id;
   logic [32:0] e_c [4];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_age <= -1; m_id <= 1'b0; m_last <= 1'b1;
         e_gnt <= 2'b00; e_busy <= 1'b0; e_done <= 1'b0; e_id <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            e_c[k] <= '0;
            p_c[k] <= '0;
         end
      end else begin
         e_gnt  <= 2'b00;
         e_done <= 1'b0;
         if (m_age == -1 || m_age == 9) begin
            if (req != 2'b00) begin
               m_age  <= 0;
               m_id   <= pick(req, m_last);
               e_gnt  <= pick(req, m_last) ? 2'b10 : 2'b01;
               e_busy <= 1'b1;
               for (int k = 0; k < 4; k++)
                  p_c[k] <= cres(pick(req, m_last) ? ops1 : ops0, k / 2, k % 2);
            end else begin
               m_age  <= -1;
               e_busy <= 1'b0;
            end
         end else begin
            m_age <= m_age + 1;
            if (m_age == 8) begin
               e_done <= 1'b1;
               e_id   <= m_id;
               m_last <= m_id;
               for (int k = 0; k < 4; k++) e_c[k] <= p_c[k];
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("gnt", gnt, e_gnt);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("done_id", done_id, e_id);
      chk("c11", c11, e_c[0]);
      chk("c12", c12, e_c[1]);
      chk("c21", c21, e_c[2]);
      chk("c22", c22, e_c[3]);
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (auto_drop) req = req & ~gnt;
      end
   endtask

   task automatic wait_done(input int budget, output int cyc);
      logic seen;
      seen = 1'b0;
      cyc = 0;
      while (cyc < budget && !seen) begin
         tick(1);
         cyc++;
         if (done) seen = 1'b1;
      end
      chk("done_within_budget", seen, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_done_id", done_id, 1'b0);
      chk("rst_c11", c11, 33'd0);
      chk("rst_c22", c22, 33'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_c(input string tag, input logic [32:0] x11, x12, x21, x22);
      chk({tag, "_c11"}, c11, x11);
      chk({tag, "_c12"}, c12, x12);
      chk({tag, "_c21"}, c21, x21);
      chk({tag, "_c22"}, c22, x22);
   endtask

   int cyc;
   int n_done;
   logic [1:0] gq [$];
   int tq [$];

   initial begin
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("init_busy", busy, 1'b0);
      chk("init_c21", c21, 33'd0);
      rst = 1'b0;

      // Single job from requester 0.
      ops0 = pk(1, 2, 3, 4, 5, 6, 7, 8);
      req = 2'b01;
      tick(1);
      chk("single_gnt", gnt, 2'b01);
      wait_done(20, cyc);
      chk("single_latency", cyc, 9);
      chk("single_id", done_id, 1'b0);
      check_c("single", 33'd19, 33'd22, 33'd43, 33'd50);
      tick(1);
      chk("single_done_pulse", done, 1'b0);

      // Tie right after reset: requester 0 first, then 1 ten cycles later.
      do_reset();
      ops0 = pk(1, 1, 1, 1, 1, 1, 1, 1);
      ops1 = pk(2, 0, 0, 2, 3, 4, 5, 6);
      req = 2'b11;
      tick(1);
      chk("tie_gnt0", gnt, 2'b01);
      wait_done(20, cyc);
      chk("tie_id0", done_id, 1'b0);
      check_c("tie0", 33'd2, 33'd2, 33'd2, 33'd2);
      wait_done(20, cyc);
      chk("tie_gap", cyc, 10);
      chk("tie_id1", done_id, 1'b1);
      check_c("tie1", 33'd6, 33'd8, 33'd10, 33'd12);

      // Fairness: both held for four jobs.
      do_reset();
      auto_drop = 1'b0;
      req = 2'b11;
      for (int i = 1; i <= 38; i++) begin
         tick(1);
         if (gnt != 2'b00) begin
            gq.push_back(gnt);
            tq.push_back(i);
         end
      end
      req = 2'b00;
      auto_drop = 1'b1;
      wait_done(15, cyc);
      chk("fair_count", gq.size(), 4);
      if (gq.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("fair_gnt", gq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("fair_time", tq[i], 1 + 10 * i);
         end
      end
      tick(2);

      // Full-scale operands.
      ops1 = {8{16'hFFFF}};
      req = 2'b10;
      wait_done(20, cyc);
      check_c("full", 33'h1_FFFC_0002, 33'h1_FFFC_0002, 33'h1_FFFC_0002, 33'h1_FFFC_0002);
      tick(1);

      // Requests and operand changes while busy.
      ops0 = pk(2, 0, 1, 3, 4, 5, 6, 7);
      req = 2'b01;
      tick(1);
      chk("busy_gnt0", gnt, 2'b01);
      tick(3);
      req = 2'b10;
      ops0 = {8{16'hFFFF}};
      wait_done(20, cyc);
      chk("busy_id0", done_id, 1'b0);
      check_c("busy0", 33'd8, 33'd10, 33'd22, 33'd26);
      wait_done(20, cyc);
      chk("busy_gap", cyc, 10);
      chk("busy_id1", done_id, 1'b1);
      chk("busy_c11_1", c11, 33'h1_FFFC_0002);
      tick(1);

      // Reset in the middle of the MAC sequence.
      ops0 = pk(9, 8, 7, 6, 5, 4, 3, 2);
      req = 2'b01;
      tick(5);
      do_reset();
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (done) n_done++;
      end
      chk("midrst_no_done", n_done, 0);
      ops1 = pk(1, 2, 3, 4, 5, 6, 7, 8);
      req = 2'b10;
      tick(1);
      chk("fresh_gnt", gnt, 2'b10);
      wait_done(20, cyc);
      chk("fresh_latency", cyc, 9);
      chk("fresh_id", done_id, 1'b1);
      check_c("fresh", 33'd19, 33'd22, 33'd43, 33'd50);
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
